omsp_spm_key_writer: RTL

OMSP_SPM_KEY_WRITER -- requirements
Module: omsp_spm_key_writer

---
 rtl/omsp_spm_key_writer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/omsp_spm_key_writer.sv
// Loads a KEY_WORDS x 16-bit key into the selected protected module, one word per strobe.
// Optional macro SPM_KEY_READBACK_EN adds a shadow copy and a read-back compare (CHECK state).
`ifndef SECURITY
`define SECURITY 64
`endif

// state  | meaning
// IDLE   | waiting for start; spm_key_select holds the last target
// SELECT | one cycle to confirm the selected module is enabled
// WRITE  | streaming key words, one per accepted handshake
// CHECK  | wait one cycle, then compare key_out with the shadow key
// FINISH | pulse done, return to IDLE
module omsp_spm_key_writer #(
  parameter int KEY_WORDS = `SECURITY/16
) (
  input  logic                   mclk,
  input  logic                   puc_rst,
  input  logic                   start,
  input  logic [15:0]            spm_id,
  input  logic                   word_valid,
  input  logic [15:0]            word_data,
  output logic                   word_ready,
  output logic [15:0]            spm_key_select,
  input  logic                   spm_key_select_valid,
  output logic                   write_key,
  output logic [15:0]            key_in,
  input  logic [0:`SECURITY-1]   key_out,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int CW = $clog2(KEY_WORDS+1);
  localparam logic [CW-1:0] LAST = CW'(KEY_WORDS-1);
  localparam logic [CW-1:0] FULL = CW'(KEY_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WRITE,
`ifdef SPM_KEY_READBACK_EN
    CHECK,
`endif
    FINISH
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [15:0]     sel_q, sel_next;
  logic            done_q, done_next;
  logic            error_q, error_next;
  logic            accept;

  // Counter bound keeps a word beyond the last one from ever being accepted.
  assign word_ready     = (state == WRITE) && spm_key_select_valid && (cnt < FULL);
  assign accept         = word_ready && word_valid;
  assign write_key      = accept;
  assign key_in         = accept ? word_data : 16'h0000;
  assign busy           = (state != IDLE);
  assign spm_key_select = sel_q;
  assign done           = done_q;
  assign error          = error_q;

`ifdef SPM_KEY_READBACK_EN
  logic [0:`SECURITY-1] shadow;
  logic                 chk_armed, chk_armed_next;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      shadow    <= '0;
      chk_armed <= 1'b0;
    end else begin
      chk_armed <= chk_armed_next;
      for (int i = 0; i < KEY_WORDS; i++) begin
        if (accept && (cnt == CW'(i)))
          shadow[16*i +: 16] <= word_data;
      end
    end
  end
`else
  logic unused_key_out;
  assign unused_key_out = ^key_out;
`endif

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sel_q   <= 16'h0000;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      sel_q   <= sel_next;
      done_q  <= done_next;
      error_q <= error_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sel_next   = sel_q;
    error_next = 1'b0;
`ifdef SPM_KEY_READBACK_EN
    chk_armed_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          sel_next   = spm_id;
          cnt_next   = '0;
          state_next = SELECT;
        end
      end
      SELECT: begin
        if (spm_key_select_valid) begin
          state_next = WRITE;
        end else begin
          error_next = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE: begin
        if (!spm_key_select_valid) begin
          error_next = 1'b1;
          state_next = IDLE;
        end else if (accept) begin
          cnt_next = cnt + CW'(1);
          if (cnt == LAST) begin
`ifdef SPM_KEY_READBACK_EN
            state_next = CHECK;
`else
            state_next = FINISH;
`endif
          end
        end
      end
`ifdef SPM_KEY_READBACK_EN
      CHECK: begin
        // First CHECK cycle lets the module's key port settle before comparing.
        if (!chk_armed) begin
          chk_armed_next = 1'b1;
        end else if (key_out == shadow) begin
          state_next = FINISH;
        end else begin
          error_next = 1'b1;
          state_next = IDLE;
        end
      end
`endif
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    done_next = (state_next == FINISH);
  end

endmodule
